// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB first, Reps times, with Gap idle cycles between repetitions.
// Latency: first pattern bit is on Out in the cycle after the edge that accepts Start; all outputs are decoded from registers.
// Backpressure: none; Start is only sampled in IDLE, and the block ignores it while a transfer is running.
//
// Ports:
//   Clk, Rst                 - clock (rising edge), asynchronous active-low reset
//   Start, Pattern, Reps, Gap - transfer request and its parameters, captured together on an accepted Start
//   Out, Valid, Last         - serial bit, bit-valid qualifier, final bit of final repetition
//   Busy, Done, state        - transfer in progress, one-cycle completion pulse, FSM state for debug
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [PAT_W-1:0] Pattern,
  input  logic [REP_W-1:0] Reps,
  input  logic [GAP_W-1:0] Gap,
  output logic             Out,
  output logic             Valid,
  output logic             Last,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [PAT_W-1:0] pat_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] bit_idx;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      pat_reg <= '0;
      gap_reg <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A zero repetition count is not a transfer at all, so it is dropped here.
          if (Start && (Reps != '0)) begin
            pat_reg <= Pattern;
            gap_reg <= Gap;
            rep_cnt <= Reps;
            bit_idx <= IDX_TOP;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_idx == '0) begin
            if (rep_cnt == REP_W'(1)) begin
              state <= S_DONE;
            end else begin
              rep_cnt <= rep_cnt - 1'b1;
              bit_idx <= IDX_TOP;
              // With no gap the next repetition follows on the very next cycle.
              if (gap_reg != '0) begin
                gap_cnt <= gap_reg;
                state   <= S_GAP;
              end
            end
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        S_GAP: begin
          // Leaving on a count of one makes the gap exactly gap_reg cycles long.
          if (gap_cnt == GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pure decode of registered state; no input reaches an output in the same cycle.
  always_comb begin
    Valid = (state == S_SEND);
    Out   = Valid & pat_reg[bit_idx];
    Last  = Valid && (bit_idx == '0) && (rep_cnt == REP_W'(1));
    Busy  = (state == S_SEND) || (state == S_GAP);
    Done  = (state == S_DONE);
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

  logic       Clk;
  logic       Rst;
  logic       Start;
  logic [3:0] Pattern;
  logic [3:0] Reps;
  logic [1:0] Gap;
  logic       Out;
  logic       Valid;
  logic       Last;
  logic       Busy;
  logic       Done;
  logic [1:0] state;

  int checks;
  int errors;

  // Per-cycle capture, shifted in so the first captured cycle is the leftmost bit.
  logic [63:0]  cap_out;
  logic [63:0]  cap_val;
  logic [63:0]  cap_last;
  logic [63:0]  cap_busy;
  logic [63:0]  cap_done;
  logic [127:0] cap_st;

  seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP_W(2)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pattern(Pattern), .Reps(Reps), .Gap(Gap),
    .Out(Out), .Valid(Valid), .Last(Last), .Busy(Busy), .Done(Done), .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic sample_now();
    cap_out  = {cap_out[62:0], Out};
    cap_val  = {cap_val[62:0], Valid};
    cap_last = {cap_last[62:0], Last};
    cap_busy = {cap_busy[62:0], Busy};
    cap_done = {cap_done[62:0], Done};
    cap_st   = {cap_st[125:0], state};
  endtask

  task automatic clear_cap();
    cap_out = '0; cap_val = '0; cap_last = '0; cap_busy = '0; cap_done = '0; cap_st = '0;
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic start_xfer(input logic [3:0] pat, input logic [3:0] reps, input logic [1:0] gap);
    @(negedge Clk);
    Pattern = pat; Reps = reps; Gap = gap; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic capture(input int n);
    clear_cap();
    for (int i = 0; i < n; i++) begin
      sample_now();
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b0; Pattern = '0; Reps = '0; Gap = '0;
    #2;
    checks++;
    if ({Out, Valid, Last, Busy, Done, state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {Out, Valid, Last, Busy, Done, state}, 7'b0);
    end
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({Out, Valid, Last, Busy, Done, state} !== 7'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp %b", {Out, Valid, Last, Busy, Done, state}, 7'b0);
    end
  endtask

  task automatic test_single();
    start_xfer(4'b1010, 4'd1, 2'd0);
    capture(6);
    checks++;
    if (cap_out[5:0] !== 6'b101000) begin errors++; $display("FAIL single_out got %b exp %b", cap_out[5:0], 6'b101000); end
    checks++;
    if (cap_val[5:0] !== 6'b111100) begin errors++; $display("FAIL single_valid got %b exp %b", cap_val[5:0], 6'b111100); end
    checks++;
    if (cap_last[5:0] !== 6'b000100) begin errors++; $display("FAIL single_last got %b exp %b", cap_last[5:0], 6'b000100); end
    checks++;
    if (cap_done[5:0] !== 6'b000010) begin errors++; $display("FAIL single_done got %b exp %b", cap_done[5:0], 6'b000010); end
    checks++;
    if (cap_st[11:0] !== 12'b01_01_01_01_11_00) begin errors++; $display("FAIL single_state got %b exp %b", cap_st[11:0], 12'b010101011100); end
  endtask

  task automatic test_back_to_back();
    int det_s;
    int det_cnt;
    start_xfer(4'b1010, 4'd3, 2'd0);
    capture(14);
    checks++;
    if (cap_out[13:0] !== 14'b10101010101000) begin errors++; $display("FAIL b2b_out got %b exp %b", cap_out[13:0], 14'b10101010101000); end
    checks++;
    if (cap_val[13:0] !== 14'b11111111111100) begin errors++; $display("FAIL b2b_valid got %b exp %b", cap_val[13:0], 14'b11111111111100); end
    checks++;
    if (cap_busy[13:0] !== 14'b11111111111100) begin errors++; $display("FAIL b2b_busy got %b exp %b", cap_busy[13:0], 14'b11111111111100); end
    checks++;
    if ({cap_last[13:0], cap_done[13:0]} !== {14'b00000000000100, 14'b00000000000010}) begin
      errors++; $display("FAIL b2b_last_done got %b %b exp 00000000000100 00000000000010", cap_last[13:0], cap_done[13:0]);
    end
    // Non-overlapping 1010 detector over the twelve valid bits.
    det_s = 0; det_cnt = 0;
    for (int i = 13; i >= 2; i--) begin
      case (det_s)
        0: det_s = cap_out[i] ? 1 : 0;
        1: det_s = cap_out[i] ? 1 : 2;
        2: det_s = cap_out[i] ? 3 : 0;
        default: begin
          if (!cap_out[i]) begin det_cnt++; det_s = 0; end
          else det_s = 1;
        end
      endcase
    end
    checks++;
    if (det_cnt !== 3) begin errors++; $display("FAIL b2b_detect got %0d exp %0d", det_cnt, 3); end
  endtask

  task automatic test_gap();
    start_xfer(4'b1001, 4'd2, 2'd2);
    capture(12);
    checks++;
    if (cap_out[11:0] !== 12'b100100100100) begin errors++; $display("FAIL gap_out got %b exp %b", cap_out[11:0], 12'b100100100100); end
    checks++;
    if (cap_val[11:0] !== 12'b111100111100) begin errors++; $display("FAIL gap_valid got %b exp %b", cap_val[11:0], 12'b111100111100); end
    checks++;
    if (cap_busy[11:0] !== 12'b111111111100) begin errors++; $display("FAIL gap_busy got %b exp %b", cap_busy[11:0], 12'b111111111100); end
    checks++;
    if ({cap_last[11:0], cap_done[11:0]} !== {12'b000000000100, 12'b000000000010}) begin
      errors++; $display("FAIL gap_last_done got %b %b exp 000000000100 000000000010", cap_last[11:0], cap_done[11:0]);
    end
    checks++;
    if (cap_st[23:0] !== 24'b01_01_01_01_10_10_01_01_01_01_11_00) begin
      errors++; $display("FAIL gap_state got %b exp %b", cap_st[23:0], 24'b010101011010010101011100);
    end
  endtask

  task automatic test_zero_reps();
    @(negedge Clk);
    Pattern = 4'b1111; Reps = 4'd0; Gap = 2'd1; Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      checks++;
      if ({Out, Valid, Last, Busy, Done, state} !== 7'b0) begin
        errors++; $display("FAIL zero_reps_cycle%0d got %b exp %b", i, {Out, Valid, Last, Busy, Done, state}, 7'b0);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_ignore_start();
    start_xfer(4'b1010, 4'd2, 2'd0);
    clear_cap();
    for (int i = 0; i < 16; i++) begin
      sample_now();
      if (i == 2) begin
        Start = 1'b1; Pattern = 4'b0110; Reps = 4'd1; Gap = 2'd3;
      end
      if (i == 10) Start = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (cap_out[15:0] !== 16'b1010101000011000) begin errors++; $display("FAIL ignore_out got %b exp %b", cap_out[15:0], 16'b1010101000011000); end
    checks++;
    if (cap_done[15:0] !== 16'b0000000010000010) begin errors++; $display("FAIL ignore_done got %b exp %b", cap_done[15:0], 16'b0000000010000010); end
    checks++;
    if ({cap_val[15:0], cap_last[15:0]} !== {16'b1111111100111100, 16'b0000000100000100}) begin
      errors++; $display("FAIL ignore_valid_last got %b %b exp 1111111100111100 0000000100000100", cap_val[15:0], cap_last[15:0]);
    end
    checks++;
    if (cap_st[31:0] !== 32'b01_01_01_01_01_01_01_01_11_00_01_01_01_01_11_00) begin
      errors++; $display("FAIL ignore_state got %b exp %b", cap_st[31:0], 32'b01010101010101011100010101011100);
    end
  endtask

  task automatic test_async_reset();
    start_xfer(4'b1010, 4'd3, 2'd1);
    @(posedge Clk);
    #2;
    checks++;
    if ({Out, Valid, state} !== 4'b0101) begin errors++; $display("FAIL arst_second_bit got %b exp %b", {Out, Valid, state}, 4'b0101); end
    Rst = 1'b0;
    #1;
    checks++;
    if ({Out, Valid, Last, Busy, Done, state} !== 7'b0) begin
      errors++; $display("FAIL arst_immediate got %b exp %b", {Out, Valid, Last, Busy, Done, state}, 7'b0);
    end
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;
    capture(3);
    checks++;
    if ({cap_val[2:0], cap_busy[2:0], cap_done[2:0], cap_st[5:0]} !== 15'b0) begin
      errors++; $display("FAIL arst_after_release got %b exp %b", {cap_val[2:0], cap_busy[2:0], cap_done[2:0], cap_st[5:0]}, 15'b0);
    end
    start_xfer(4'b0110, 4'd1, 2'd0);
    capture(6);
    checks++;
    if ({cap_out[5:0], cap_val[5:0], cap_done[5:0]} !== {6'b011000, 6'b111100, 6'b000010}) begin
      errors++; $display("FAIL arst_fresh got %b %b %b exp 011000 111100 000010", cap_out[5:0], cap_val[5:0], cap_done[5:0]);
    end
  endtask

  task automatic test_max_reps();
    int vcnt;
    start_xfer(4'b1100, 4'd15, 2'd0);
    capture(62);
    vcnt = 0;
    for (int i = 0; i < 62; i++) if (cap_val[i]) vcnt++;
    checks++;
    if (vcnt !== 60) begin errors++; $display("FAIL max_reps_valid_count got %0d exp %0d", vcnt, 60); end
    checks++;
    if ({cap_last[2], cap_done[1], cap_st[1:0]} !== 4'b1100) begin
      errors++; $display("FAIL max_reps_end got %b exp %b", {cap_last[2], cap_done[1], cap_st[1:0]}, 4'b1100);
    end
    checks++;
    if (cap_out[61:54] !== 8'b11001100) begin errors++; $display("FAIL max_reps_head got %b exp %b", cap_out[61:54], 8'b11001100); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_cap();
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_zero_reps();
    test_ignore_start();
    test_async_reset();
    test_max_reps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
